// File: rtl/psum_drain_arbiter_if.sv
// Drain-path bundle: PE psum FIFO pop side plus the global-buffer write port.
// The arbiter is the master; the PE array / buffer wrapper is the slave.
interface psum_drain_arbiter_if #(
  parameter int unsigned N                        = 4,
  parameter int unsigned DATA_WIDTH               = 16,
  parameter int unsigned GLOBAL_BUFFER_ADDR_WIDTH = 8
);
  logic [N-1:0]                        valid_psum;
  logic [N*DATA_WIDTH-1:0]             psum_data;
  logic [N-1:0]                        ren_psum;
  logic                                wen_global_buffer;
  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] waddr_global_buffer;
  logic [DATA_WIDTH-1:0]               wdata_global_buffer;

  modport master (
    input  valid_psum,
    input  psum_data,
    output ren_psum,
    output wen_global_buffer,
    output waddr_global_buffer,
    output wdata_global_buffer
  );

  modport slave (
    output valid_psum,
    output psum_data,
    input  ren_psum,
    input  wen_global_buffer,
    input  waddr_global_buffer,
    input  wdata_global_buffer
  );
endinterface

// File: rtl/psum_drain_arbiter.sv
// Round-robin drain of N PE psum FIFOs into a single global-buffer write port.
// One word per ARB -> READ -> WRITE pass; the FIFO head is registered, so the
// popped word is presented in the cycle after the pop strobe.
module psum_drain_arbiter #(
  parameter int unsigned N                        = 4,
  parameter int unsigned N_WIDTH                  = 2,
  parameter int unsigned DATA_WIDTH               = 16,
  parameter int unsigned GLOBAL_BUFFER_ADDR_WIDTH = 8,
  parameter int unsigned GLOBAL_BUFFER_DEPTH      = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Start,
  input  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] base_addr,
  input  logic                                all_done,
  psum_drain_arbiter_if.master                bus,
  output logic [N_WIDTH-1:0]                  grant_id,
  output logic                                busy,
  output logic                                done_out,
  output logic [GLOBAL_BUFFER_ADDR_WIDTH:0]   word_count,
  output logic                                overflow
);

  localparam int unsigned AW   = GLOBAL_BUFFER_ADDR_WIDTH;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArb   = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW:0]        wcnt_q, wcnt_d;
  logic [N_WIDTH-1:0] ptr_q, ptr_d;
  logic [N_WIDTH-1:0] grant_q, grant_d;
  logic               ovf_q, ovf_d;

  logic               found;
  logic [IdxW-1:0]    idx;
  logic [N_WIDTH-1:0] pick;
  logic               addr_wrap;

  // Circular search starting at the pointer: first valid FIFO wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = IdxW'((int'(ptr_q) + k) % int'(N));
      if (!found && bus.valid_psum[idx]) begin
        found = 1'b1;
        pick  = N_WIDTH'(idx);
      end
    end
  end

  assign addr_wrap = (addr_q == AW'(GLOBAL_BUFFER_DEPTH - 1));

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StArb;
          addr_d  = base_addr;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
          ptr_d   = '0;
        end
      end
      StArb: begin
        // Pending data takes priority over all_done so nothing is left behind.
        if (found) begin
          grant_d = pick;
          state_d = StRead;
        end else if (all_done) begin
          state_d = StDone;
        end
      end
      StRead: begin
        state_d = StWrite;
      end
      StWrite: begin
        addr_d  = addr_wrap ? '0 : addr_q + 1'b1;
        if (addr_wrap) begin
          ovf_d = 1'b1;
        end
        wcnt_d  = wcnt_q + 1'b1;
        ptr_d   = (grant_q == N_WIDTH'(N - 1)) ? '0 : grant_q + 1'b1;
        state_d = StArb;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wcnt_q  <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ovf_q   <= ovf_d;
    end
  end

  // Pop strobe and write-data select, both decoded from the registered grant.
  always_comb begin
    bus.ren_psum            = '0;
    bus.wdata_global_buffer = '0;
    for (int i = 0; i < int'(N); i++) begin
      bus.ren_psum[i] = (state_q == StRead) && (grant_q == N_WIDTH'(i));
      if ((state_q == StWrite) && (grant_q == N_WIDTH'(i))) begin
        bus.wdata_global_buffer = bus.psum_data[i*DW +: DW];
      end
    end
  end

  assign bus.wen_global_buffer   = (state_q == StWrite);
  assign bus.waddr_global_buffer = (state_q == StWrite) ? addr_q : '0;

  assign grant_id   = grant_q;
  assign busy       = (state_q != StIdle);
  assign done_out   = (state_q == StDone);
  assign word_count = wcnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_psum_drain_arbiter.sv
// Bench for psum_drain_arbiter: PE FIFO model with registered heads, and a
// scoreboard of expected global-buffer writes checked as they appear.
module tb_psum_drain_arbiter;

  localparam int N  = 4;
  localparam int NW = 2;
  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [N-1:0]  ren;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          all_done;
  logic [NW-1:0] grant_id;
  logic          busy;
  logic          done_out;
  logic [AW:0]   word_count;
  logic          overflow;

  psum_drain_arbiter_if #(.N(N), .DATA_WIDTH(DW), .GLOBAL_BUFFER_ADDR_WIDTH(AW)) bus ();

  psum_drain_arbiter #(
    .N                       (N),
    .N_WIDTH                 (NW),
    .DATA_WIDTH              (DW),
    .GLOBAL_BUFFER_ADDR_WIDTH(AW),
    .GLOBAL_BUFFER_DEPTH     (256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (start),
    .base_addr (base_addr),
    .all_done  (all_done),
    .bus       (bus.master),
    .grant_id  (grant_id),
    .busy      (busy),
    .done_out  (done_out),
    .word_count(word_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // PE FIFO model: mem/wr_cnt written by the stimulus, rd_cnt/pdata by pops.
  logic [DW-1:0] mem [N][16];
  int            wr_cnt [N];
  int            rd_cnt [N];
  logic [DW-1:0] pdata [N];
  logic          pe_clr;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pe_clr) begin
        rd_cnt[i] <= 0;
      end else if (bus.ren_psum[i]) begin
        pdata[i]  <= mem[i][rd_cnt[i]];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  assign bus.psum_data  = {pdata[3], pdata[2], pdata[1], pdata[0]};
  assign bus.valid_psum = {wr_cnt[3] != rd_cnt[3], wr_cnt[2] != rd_cnt[2],
                           wr_cnt[1] != rd_cnt[1], wr_cnt[0] != rd_cnt[0]};

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_wen_cyc;
  int           ren_cnt;
  logic [N-1:0] prev_ren;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and check whatever the DUT presents there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.ren_psum != '0) begin
      ren_cnt++;
      check("ren_onehot", 32'($onehot(bus.ren_psum)), 32'd1);
    end
    if (bus.wen_global_buffer) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("waddr", 32'(bus.waddr_global_buffer), 32'(e.addr));
        check("wdata", 32'(bus.wdata_global_buffer), 32'(e.data));
        check("ren_before_wen", 32'(prev_ren), 32'(e.ren));
        if (last_wen_cyc >= 0) check("wen_gap", 32'(cyc - last_wen_cyc), 32'd3);
      end
      last_wen_cyc = cyc;
    end else begin
      check("wdata_idle", 32'(bus.wdata_global_buffer), 32'd0);
    end
    prev_ren = bus.ren_psum;
  endtask

  task automatic clear_pes();
    pe_clr = 1'b1;
    for (int i = 0; i < N; i++) wr_cnt[i] = 0;
    tick();
    pe_clr = 1'b0;
  endtask

  task automatic preload(input int pe, input logic [DW-1:0] d);
    mem[pe][wr_cnt[pe]] = d;
    wr_cnt[pe] = wr_cnt[pe] + 1;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int pe);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.ren  = N'(1) << pe;
    sb.push_back(e);
  endtask

  task automatic start_session(input logic [AW-1:0] base);
    start        = 1'b1;
    base_addr    = base;
    last_wen_cyc = -1;
    ren_cnt      = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int max, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      n++;
      if (done_out) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic hit;
    rst = 1'b1; start = 1'b0; base_addr = '0; all_done = 1'b0; pe_clr = 1'b1;
    prev_ren = '0; last_wen_cyc = -1; ren_cnt = 0;
    for (int i = 0; i < N; i++) begin
      wr_cnt[i] = 0;
      pdata[i]  = '0;
    end
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ren", 32'(bus.ren_psum), 32'd0);
    check("rst_wen", 32'(bus.wen_global_buffer), 32'd0);
    check("rst_waddr", 32'(bus.waddr_global_buffer), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_wcnt", 32'(word_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    pe_clr = 1'b0;
    tick();

    // Single source: PE2 holds A,B at base 8.
    preload(2, 16'hA0A0); preload(2, 16'hB0B0);
    expect_write(8'd8, 16'hA0A0, 2); expect_write(8'd9, 16'hB0B0, 2);
    start_session(8'd8);
    all_done = 1'b1;
    run_until_done(100, n);
    check("single_wcnt", 32'(word_count), 32'd2);
    check("single_ren_cnt", 32'(ren_cnt), 32'd2);
    check("single_sb_left", 32'(sb.size()), 32'd0);
    check("single_ovf", 32'(overflow), 32'd0);
    tick();
    check("single_done_pulse", 32'(done_out), 32'd0);
    check("single_idle", 32'(busy), 32'd0);
    check("single_wcnt_hold", 32'(word_count), 32'd2);

    // Fairness: every FIFO valid, round-robin from PE0.
    clear_pes();
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < N; p++) begin
        preload(p, DW'(16'h1000 * (p + 1) + s));
        expect_write(AW'(8'h20 + s * N + p), DW'(16'h1000 * (p + 1) + s), p);
      end
    end
    start_session(8'h20);
    run_until_done(100, n);
    check("fair_wcnt", 32'(word_count), 32'd8);
    check("fair_sb_left", 32'(sb.size()), 32'd0);

    // Address wrap at the top of the buffer.
    clear_pes();
    for (int s = 0; s < 3; s++) begin
      preload(0, DW'(16'h0C00 + s));
    end
    expect_write(8'd254, 16'h0C00, 0);
    expect_write(8'd255, 16'h0C01, 0);
    expect_write(8'd0, 16'h0C02, 0);
    start_session(8'd254);
    run_until_done(100, n);
    check("wrap_ovf", 32'(overflow), 32'd1);
    check("wrap_wcnt", 32'(word_count), 32'd3);
    check("wrap_sb_left", 32'(sb.size()), 32'd0);

    // Empty session: done in the third cycle counting the Start cycle.
    clear_pes();
    start_session(8'd5);
    check("empty_ovf_clr", 32'(overflow), 32'd0);
    run_until_done(20, n);
    check("empty_done_lat", 32'(1 + n), 32'd2);
    check("empty_ren_cnt", 32'(ren_cnt), 32'd0);
    check("empty_wcnt", 32'(word_count), 32'd0);

    // Reset while in READ, then a fresh session from address 0.
    clear_pes();
    all_done = 1'b0;
    preload(1, 16'h5A5A);
    start_session(8'h40);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (bus.ren_psum != '0) hit = 1'b1;
    end
    check("rst_reach_read", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check("async_ren", 32'(bus.ren_psum), 32'd0);
    check("async_wen", 32'(bus.wen_global_buffer), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    tick();
    check("async_grant", 32'(grant_id), 32'd0);
    check("async_wcnt", 32'(word_count), 32'd0);
    rst = 1'b0;
    tick();
    check("no_resume", 32'(busy), 32'd0);
    all_done = 1'b1;
    expect_write(8'd0, 16'h5A5A, 1);
    start_session(8'd0);
    run_until_done(100, n);
    check("after_rst_wcnt", 32'(word_count), 32'd1);
    check("after_rst_sb_left", 32'(sb.size()), 32'd0);

    // Start pulse while in WRITE must not reload the address.
    clear_pes();
    for (int s = 0; s < 3; s++) begin
      preload(3, DW'(16'h3300 + s));
      expect_write(AW'(8'h80 + s), DW'(16'h3300 + s), 3);
    end
    start_session(8'h80);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (bus.wen_global_buffer) hit = 1'b1;
    end
    check("busy_reach_write", 32'(hit), 32'd1);
    start = 1'b1;
    base_addr = 8'h10;
    tick();
    start = 1'b0;
    run_until_done(100, n);
    check("busy_start_wcnt", 32'(word_count), 32'd3);
    check("busy_start_sb_left", 32'(sb.size()), 32'd0);
    tick();
    check("busy_start_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
